// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: RGB444 raster stream to double-buffered two-bank pixel RAM.
// Swaps on-screen and off-screen buffers on panel frame end.
module frame_buffer_writer #(
    parameter int COLS          = 48,
    parameter int ROWS_PER_BANK = 32,
    parameter int ADDR_W        = 12,
    parameter int PIX_W         = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PIX_W-1:0]  i_pix_data,
    input  logic              i_pix_valid,
    input  logic              i_pix_sof,
    output logic              o_pix_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [PIX_W-1:0]  o_wr_data,
    output logic              o_wr_en_b1,
    output logic              o_wr_en_b2,
    output logic              o_wr_buf,
    input  logic              i_frame_done,
    output logic              o_disp_buf,
    output logic              o_frame_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [5:0] LAST_COL      = 6'(COLS - 1);
    localparam logic [5:0] BANK_ROWS     = 6'(ROWS_PER_BANK);
    localparam logic [5:0] BANK_LAST_ROW = 6'(ROWS_PER_BANK - 1);
    localparam logic [5:0] LAST_ROW      = 6'(2 * ROWS_PER_BANK - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [5:0]        r_col;
    logic [5:0]        r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ready;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_wr_en_b1;
    logic              r_wr_en_b2;
    logic              r_wr_buf;
    logic              r_disp_buf;
    logic              r_frame_err;

    logic w_xfer;
    logic w_in_write;
    logic w_start;
    logic w_trunc;
    logic w_wr;
    logic w_bank2;
    logic w_col_end;
    logic w_bank_end;
    logic w_row_end;
    logic w_swap;

    assign w_xfer     = i_pix_valid & r_ready;
    assign w_in_write = (r_state == S_WRITE);
    // sof restarts a frame from IDLE or from anywhere inside WRITE
    assign w_start    = w_xfer & i_pix_sof &
                        ((r_state == S_IDLE) | w_in_write);
    // inside WRITE the counters always point past pixel 0, so any sof truncates
    assign w_trunc    = w_xfer & i_pix_sof & w_in_write;
    assign w_wr       = w_start | (w_xfer & w_in_write);
    assign w_bank2    = ~w_start & (r_row >= BANK_ROWS);
    assign w_col_end  = (r_col == LAST_COL);
    assign w_bank_end = w_col_end & (r_row == BANK_LAST_ROW);
    assign w_row_end  = w_col_end & (r_row == LAST_ROW);
    assign w_swap     = (r_state == S_WAIT) & i_frame_done;

    // next-state selection
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_xfer && !i_pix_sof && w_row_end) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_frame_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // state register and ready, which is low only while waiting for the swap
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != S_WAIT);
        end
    end

    // raster position and per-bank address, pointing at the next pixel
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_start) begin
            r_col  <= 6'd1;
            r_row  <= '0;
            r_addr <= ADDR_ONE;
        end else if (w_xfer && w_in_write) begin
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 6'd1;
                end
                if (w_bank_end || w_row_end) begin
                    r_addr <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_ONE;
                end
            end else begin
                r_col  <= r_col + 6'd1;
                r_addr <= r_addr + ADDR_ONE;
            end
        end
    end

    // registered RAM write port; strobes are single-cycle per accepted pixel
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en_b1 <= 1'b0;
            r_wr_en_b2 <= 1'b0;
        end else begin
            r_wr_en_b1 <= w_wr & ~w_bank2;
            r_wr_en_b2 <= w_wr & w_bank2;
            if (w_wr) begin
                r_wr_addr <= w_start ? '0 : r_addr;
                r_wr_data <= i_pix_data;
            end
        end
    end

    // buffer swap once a complete frame is waiting and the panel wraps
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_buf   <= 1'b1;
            r_disp_buf <= 1'b0;
        end else if (w_swap) begin
            r_disp_buf <= r_wr_buf;
            r_wr_buf   <= ~r_wr_buf;
        end
    end

    // single-cycle truncated-frame flag
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_trunc;
        end
    end

    assign o_pix_ready = r_ready;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_wr_en_b1  = r_wr_en_b1;
    assign o_wr_en_b2  = r_wr_en_b2;
    assign o_wr_buf    = r_wr_buf;
    assign o_disp_buf  = r_disp_buf;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: random-stimulus scoreboard bench for frame_buffer_writer.
// Frame-level reference model predicts every RAM write and the buffer indices.
module tb_frame_buffer_writer;

    localparam int FRAME    = 3072;
    localparam int BANK_PIX = 1536;

    logic        i_clk;
    logic        i_rst;
    logic [11:0] i_pix_data;
    logic        i_pix_valid;
    logic        i_pix_sof;
    logic        o_pix_ready;
    logic [11:0] o_wr_addr;
    logic [11:0] o_wr_data;
    logic        o_wr_en_b1;
    logic        o_wr_en_b2;
    logic        o_wr_buf;
    logic        i_frame_done;
    logic        o_disp_buf;
    logic        o_frame_err;

    frame_buffer_writer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pix_data   (i_pix_data),
        .i_pix_valid  (i_pix_valid),
        .i_pix_sof    (i_pix_sof),
        .o_pix_ready  (o_pix_ready),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_wr_en_b1   (o_wr_en_b1),
        .o_wr_en_b2   (o_wr_en_b2),
        .o_wr_buf     (o_wr_buf),
        .i_frame_done (i_frame_done),
        .o_disp_buf   (o_disp_buf),
        .o_frame_err  (o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int bank;
        int addr;
        int data;
        bit wbuf;
        bit err;
    } wr_t;

    wr_t exp_q[$];
    int  n_err = 0;
    int  n_chk = 0;

    // model: 0 idle, 1 writing, 2 waiting for swap
    int  m_state;
    int  m_pos;
    bit  m_wr;
    bit  m_disp;
    bit  m_rdy;
    bit  gaps;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pos   = 0;
        m_wr    = 1'b1;
        m_disp  = 1'b0;
        m_rdy   = 1'b0;
        exp_q.delete();
    endtask

    // monitor: pop and compare whenever a write strobe is presented
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                if (o_wr_en_b1 || o_wr_en_b2) begin
                    int  gb;
                    wr_t e;
                    gb = o_wr_en_b1 ? (o_wr_en_b2 ? 3 : 1) : 2;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL write_unexpected: bank %0d addr %0d, none expected",
                                 gb, o_wr_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (gb != e.bank || int'(o_wr_addr) != e.addr ||
                            int'(o_wr_data) != e.data || o_wr_buf != e.wbuf ||
                            o_frame_err != e.err) begin
                            n_err++;
                            $display("FAIL write: got b%0d a%0d d%0d buf%0d err%0d expected b%0d a%0d d%0d buf%0d err%0d",
                                     gb, o_wr_addr, o_wr_data, o_wr_buf, o_frame_err,
                                     e.bank, e.addr, e.data, e.wbuf, e.err);
                        end
                    end
                end else begin
                    chk("frame_err_no_write", int'(o_frame_err), 0);
                end
            end
        end
    end

    // one clock of stimulus plus model update for that edge
    task automatic step(input bit v, input logic [11:0] d, input bit s,
                        input bit fd, output bit x);
        @(negedge i_clk);
        chk("ready", int'(o_pix_ready), int'(m_rdy));
        chk("disp_buf", int'(o_disp_buf), int'(m_disp));
        chk("wr_buf", int'(o_wr_buf), int'(m_wr));
        i_pix_valid  = v;
        i_pix_data   = d;
        i_pix_sof    = s;
        i_frame_done = fd;
        x = v && m_rdy;
        if (m_state == 2 && fd) begin
            m_disp  = m_wr;
            m_wr    = !m_wr;
            m_state = 0;
        end
        if (x) begin
            if (s) begin
                exp_q.push_back('{1, 0, int'(d), m_wr, m_state == 1});
                m_pos   = 1;
                m_state = 1;
            end else if (m_state == 1) begin
                exp_q.push_back('{(m_pos < BANK_PIX) ? 1 : 2, m_pos % BANK_PIX,
                                  int'(d), m_wr, 1'b0});
                m_pos++;
                if (m_pos == FRAME) m_state = 2;
            end
        end
        m_rdy = (m_state != 2);
    endtask

    task automatic idle(input int n, input bit fd_rand);
        bit x;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 12'($urandom), 1'($urandom), fd_rand ? 1'($urandom) : 1'b0, x);
        end
    endtask

    task automatic send(input logic [11:0] d, input bit s, input bit fd);
        bit x;
        int tries;
        if (gaps && ($urandom % 4 == 0)) idle($urandom_range(1, 3), 1'b1);
        tries = 0;
        x = 1'b0;
        while (!x && tries < 8) begin
            step(1'b1, d, s, fd, x);
            tries++;
        end
        if (!x) chk("send_timeout", tries, 0);
    endtask

    task automatic swap_pulse();
        bit x;
        idle(3, 1'b0);
        step(1'b0, 12'd0, 1'b0, 1'b1, x);
        idle(2, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(o_pix_ready), 0);
        chk({tag, "_en_b1"}, int'(o_wr_en_b1), 0);
        chk({tag, "_en_b2"}, int'(o_wr_en_b2), 0);
        chk({tag, "_addr"}, int'(o_wr_addr), 0);
        chk({tag, "_data"}, int'(o_wr_data), 0);
        chk({tag, "_err"}, int'(o_frame_err), 0);
        chk({tag, "_wr_buf"}, int'(o_wr_buf), 1);
        chk({tag, "_disp_buf"}, int'(o_disp_buf), 0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1 chk("ready_before_first_edge", int'(o_pix_ready), 0);
        m_rdy = 1'b1;
    endtask

    initial begin
        bit x;
        i_rst        = 1'b1;
        i_pix_data   = '0;
        i_pix_valid  = 1'b0;
        i_pix_sof    = 1'b0;
        i_frame_done = 1'b0;
        gaps         = 1'b0;
        model_reset();
        #1 i_rst = 1'b0;
        #1 check_reset_outputs("reset");
        release_reset();

        // pre-sof garbage, then a clean frame with data = index
        for (int i = 0; i < 10; i++) send(12'(i + 7), 1'b0, 1'b0);
        for (int i = 0; i < FRAME; i++) send(12'(i), i == 0, 1'b0);
        swap_pulse();

        // random data and gaps; frame_done on the last-pixel edge is ignored
        gaps = 1'b1;
        for (int i = 0; i < FRAME; i++) send(12'($urandom), i == 0, i == FRAME - 1);
        swap_pulse();

        // truncation at pixel 100, then a complete frame from that pixel
        for (int i = 0; i < 100; i++) send(12'($urandom), i == 0, 1'b0);
        send(12'hABC, 1'b1, 1'b0);
        for (int i = 1; i < FRAME; i++) send(12'($urandom), 1'b0, 1'b0);
        swap_pulse();

        // async reset while the write strobe of pixel 2000 is high
        gaps = 1'b0;
        for (int i = 0; i < 2000; i++) send(12'(i), i == 0, 1'b0);
        step(1'b1, 12'd2000, 1'b0, 1'b0, x);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        i_pix_valid = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        release_reset();

        // restart after reset lands in bank 1 at address 0 of buffer 1
        gaps = 1'b1;
        for (int i = 0; i < 120; i++) send(12'($urandom), i == 0, 1'b0);
        idle(3, 1'b1);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Upstream stage of the HUB75 panel driver. Accepts a raster RGB444 pixel stream over a valid/ready handshake.
- Writes each frame into the off-screen half of a double-buffered, two-bank pixel RAM. Upper-half rows go to bank 1, lower-half rows to bank 2.
- On display frame end, swaps the on-screen and off-screen buffers so the panel driver only ever reads complete frames.

Parameters:
- COLS, 48, pixels per row (panel shift length).
- ROWS_PER_BANK, 32, rows per bank (matches the 5-bit row select).
- ADDR_W, 12, RAM address width per buffer.
- PIX_W, 12, pixel width: R[11:8], G[7:4], B[3:0].

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_pix_data  in  PIX_W  incoming pixel.
- i_pix_valid  in  1  pixel present.
- i_pix_sof  in  1  qualifies i_pix_data as row 0, col 0 of a frame.
- o_pix_ready  out  1  block accepts a pixel this cycle.
- o_wr_addr  out  ADDR_W  write address within the selected buffer.
- o_wr_data  out  PIX_W  write data.
- o_wr_en_b1  out  1  write strobe, bank 1 (rows 0..31).
- o_wr_en_b2  out  1  write strobe, bank 2 (rows 32..63).
- o_wr_buf  out  1  buffer index currently being written.
- i_frame_done  in  1  one-cycle pulse from the panel driver when the row select wraps after the last bit-plane.
- o_disp_buf  out  1  buffer index the panel driver reads.
- o_frame_err  out  1  one-cycle pulse on a truncated frame.

Behaviour:
- Transfer rule: a pixel transfers on a rising edge where i_pix_valid and o_pix_ready are both 1.
- Reset (i_rst=0, asynchronous):
  - o_pix_ready=0, o_wr_en_b1=0, o_wr_en_b2=0, o_wr_addr=0, o_wr_data=0, o_frame_err=0.
  - o_wr_buf=1, o_disp_buf=0.
  - State=IDLE; row, column and address counters=0.
  - o_pix_ready rises on the first clock after release.
  - Reset mid-frame discards the partial frame; buffer indices return to the reset values.
- FSM states: IDLE, WRITE, WAIT_SWAP.
- IDLE:
  - o_pix_ready=1.
  - Pixels without i_pix_sof are consumed and dropped; no write.
  - Transfer with sof: write it as pixel 0, go to WRITE.
- WRITE:
  - o_pix_ready=1.
  - Each transfer writes one pixel.
  - Column counter 0..COLS-1, then wraps to 0 and row increments.
  - Address counter increments by 1 per pixel; no multiplier. It resets to 0 when row goes 31 to 32.
  - Rows 0..31 assert o_wr_en_b1; rows 32..63 assert o_wr_en_b2.
  - After pixel row 63, col 47 (3072nd transfer), go to WAIT_SWAP.
- Write latency:
  - o_wr_addr, o_wr_data and the bank strobe are registered.
  - They are valid the cycle after the transfer edge; the strobe is high exactly 1 cycle per pixel.
  - The strobe is 0 on cycles without a transfer.
- Truncated frame:
  - Condition: a transfer with i_pix_sof=1 in WRITE, at any position other than pixel 0.
  - o_frame_err=1 for one cycle.
  - Counters restart and that pixel is written as row 0, col 0.
  - o_wr_buf is unchanged.
- WAIT_SWAP:
  - o_pix_ready=0.
  - On i_frame_done=1: o_disp_buf<=o_wr_buf, o_wr_buf<=~o_wr_buf, go to IDLE; ready returns next cycle.
  - i_frame_done in IDLE or WRITE is ignored (no swap, no latch).
  - i_frame_done on the same edge as the last-pixel transfer is ignored; the next pulse swaps.
- Buffer invariant: o_wr_buf is always ~o_disp_buf.
- i_pix_sof without i_pix_valid is ignored.
- Counter widths: column 6 bits, row 6 bits, address ADDR_W bits. The maximum address used is 1535; no wrap past it.

Test Plan:
- Reset then full frame: 3072 valid pixels, data equals the index mod 4096, sof on the first. Required response:
  - Bank-1 strobes at addresses 0..1535 for indices 0..1535.
  - Bank-2 strobes at addresses 0..1535 for indices 1536..3071.
  - o_wr_buf=1 throughout; ready drops after the last transfer.
- Swap: after a full frame, pulse i_frame_done → o_disp_buf=1, o_wr_buf=0 next cycle, ready=1. A second frame plus pulse → o_disp_buf=0.
- Pre-sof garbage: 10 pixels with sof=0, then a frame → no strobes for the first 10 pixels; the first write is at address 0, bank 1.
- Truncation: sof at pixel 100 (row 2, col 4) → o_frame_err pulses once; that pixel is written at address 0, bank 1; the full frame then completes normally.
- Backpressure and frame_done timing:
  - Random valid gaps → addresses stay contiguous and strobes occur only on transfers.
  - i_frame_done during WRITE and on the last-pixel edge → no swap.
- Async reset asserted at pixel 2000 → all outputs return to reset values immediately, without a clock edge; o_disp_buf=0, o_wr_buf=1.
